axi_slave_demux_w: RTL and testbench

AXI_SLAVE_DEMUX_W -- requirements
Module: axi_slave_demux_w

---
 rtl/axi_ic_pkg.sv | 18 +
 rtl/axi_slave_demux_w_if.sv | 57 +++++
 rtl/axi_w_addr_decode.sv | 18 +
 rtl/axi_slave_demux_w.sv | 254 +++++++++++++++++++++++++
 tb/tb_axi_slave_demux_w.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_ic_pkg.sv
// Shared types for the AXI write-channel slave demux.
// FSM states, BRESP codes and slave count.
package axi_ic_pkg;

  localparam int NUM_SLV = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_slave_demux_w_if.sv
// AXI4 write-side bundle: AW, W and B channels.
// master drives requests, slave drives ready/response.
interface axi_slave_demux_w_if #(
  parameter int DATA_WIDTH = 1024,
  parameter int ADDR_WIDTH = 64,
  parameter int ID_WIDTH   = 8,
  parameter int USER_WIDTH = 8,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) ();

  logic [ID_WIDTH-1:0]   AWID;
  logic [ADDR_WIDTH-1:0] AWADDR;
  logic [7:0]            AWLEN;
  logic [2:0]            AWSIZE;
  logic [1:0]            AWBURST;
  logic                  AWLOCK;
  logic [3:0]            AWCACHE;
  logic [2:0]            AWPROT;
  logic [3:0]            AWQOS;
  logic [3:0]            AWREGION;
  logic [USER_WIDTH-1:0] AWUSER;
  logic                  AWVALID;
  logic                  AWREADY;

  logic [DATA_WIDTH-1:0] WDATA;
  logic [STRB_WIDTH-1:0] WSTRB;
  logic                  WLAST;
  logic [USER_WIDTH-1:0] WUSER;
  logic                  WVALID;
  logic                  WREADY;

  logic [ID_WIDTH-1:0]   BID;
  logic [1:0]            BRESP;
  logic                  BVALID;
  logic                  BREADY;

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE,
    output AWBURST, AWLOCK, AWCACHE, AWPROT,
    output AWQOS, AWREGION, AWUSER, AWVALID,
    output WDATA, WSTRB, WLAST, WUSER, WVALID,
    output BREADY,
    input  AWREADY, WREADY,
    input  BID, BRESP, BVALID
  );

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE,
    input  AWBURST, AWLOCK, AWCACHE, AWPROT,
    input  AWQOS, AWREGION, AWUSER, AWVALID,
    input  WDATA, WSTRB, WLAST, WUSER, WVALID,
    input  BREADY,
    output AWREADY, WREADY,
    output BID, BRESP, BVALID
  );

endinterface

// File: rtl/axi_w_addr_decode.sv
// Address-to-slave decode on the two top address bits.
// Slaves not present in SLV_EN decode as DECERR.
module axi_w_addr_decode #(
  parameter int         ADDR_WIDTH = 64,
  parameter logic [3:0] SLV_EN     = 4'b1111
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [1:0]            sel,
  output logic                  decerr
);

  logic unused_low;

  assign sel        = addr[ADDR_WIDTH-1 -: 2];
  assign decerr     = ~SLV_EN[sel];
  assign unused_low = ^addr[ADDR_WIDTH-3:0];

endmodule

// File: rtl/axi_slave_demux_w.sv
// AXI4 write demux: one master to four slaves,
// one outstanding burst, local DECERR/SLVERR replies.
module axi_slave_demux_w
  import axi_ic_pkg::*;
#(
  parameter int         DATA_WIDTH = 1024,
  parameter int         ADDR_WIDTH = 64,
  parameter int         ID_WIDTH   = 8,
  parameter int         USER_WIDTH = 8,
  parameter int         STRB_WIDTH = DATA_WIDTH / 8,
  parameter logic [3:0] SLV_EN     = 4'b1111
) (
  input logic                  ACLK,
  input logic                  ARESETn,
  axi_slave_demux_w_if.slave   m,
  axi_slave_demux_w_if.master  s0,
  axi_slave_demux_w_if.master  s1,
  axi_slave_demux_w_if.master  s2,
  axi_slave_demux_w_if.master  s3
);

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic                  lock;
    logic [3:0]            cache;
    logic [2:0]            prot;
    logic [3:0]            qos;
    logic [3:0]            region;
    logic [USER_WIDTH-1:0] user;
    logic                  valid;
  } aw_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;
    logic                  last;
    logic [USER_WIDTH-1:0] user;
    logic                  valid;
  } w_t;

  state_e              state_q, state_d;
  logic [1:0]          sel_q, sel_d;
  logic                decerr_q, decerr_d;
  logic                slverr_q, slverr_d;
  logic [ID_WIDTH-1:0] id_q, id_d;
  logic [7:0]          len_q, len_d;
  logic [7:0]          cnt_q, cnt_d;

  logic [1:0] dec_sel;
  logic       dec_err;

  aw_t aw_m;
  w_t  w_m;
  aw_t aw_s [NUM_SLV];
  w_t  w_s  [NUM_SLV];

  logic [NUM_SLV-1:0]  aw_rdy, w_rdy, b_vld, b_rdy;
  logic [ID_WIDTH-1:0] b_id   [NUM_SLV];
  logic [1:0]          b_resp [NUM_SLV];

  logic                aw_en, w_en, b_en, b_loc;
  logic                w_hs, b_hs;
  logic                m_awready, m_wready, m_bvalid;
  logic [ID_WIDTH-1:0] m_bid;
  logic [1:0]          m_bresp;

  axi_w_addr_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .SLV_EN     (SLV_EN)
  ) u_dec (
    .addr   (m.AWADDR),
    .sel    (dec_sel),
    .decerr (dec_err)
  );

  assign aw_m = {m.AWID, m.AWADDR, m.AWLEN,
                 m.AWSIZE, m.AWBURST, m.AWLOCK,
                 m.AWCACHE, m.AWPROT, m.AWQOS,
                 m.AWREGION, m.AWUSER, m.AWVALID};
  assign w_m  = {m.WDATA, m.WSTRB, m.WLAST,
                 m.WUSER, m.WVALID};

  assign aw_rdy = {s3.AWREADY, s2.AWREADY,
                   s1.AWREADY, s0.AWREADY};
  assign w_rdy  = {s3.WREADY, s2.WREADY,
                   s1.WREADY, s0.WREADY};
  assign b_vld  = {s3.BVALID, s2.BVALID,
                   s1.BVALID, s0.BVALID};
  assign b_id[0]   = s0.BID;
  assign b_id[1]   = s1.BID;
  assign b_id[2]   = s2.BID;
  assign b_id[3]   = s3.BID;
  assign b_resp[0] = s0.BRESP;
  assign b_resp[1] = s1.BRESP;
  assign b_resp[2] = s2.BRESP;
  assign b_resp[3] = s3.BRESP;

  // B is answered locally for unmapped or overrun bursts
  assign b_loc = decerr_q | slverr_q;
  assign aw_en = (state_q == ST_ADDR) & ~decerr_q;
  assign w_en  = (state_q == ST_DATA) & ~decerr_q;
  assign b_en  = (state_q == ST_RESP) & ~b_loc;
  assign w_hs  = m.WVALID & m_wready;
  assign b_hs  = m_bvalid & m.BREADY;

  // next-state and per-burst bookkeeping
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    decerr_d = decerr_q;
    slverr_d = slverr_q;
    id_d     = id_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d    = '0;
        slverr_d = 1'b0;
        if (m.AWVALID) begin
          sel_d    = dec_sel;
          decerr_d = dec_err;
          id_d     = m.AWID;
          len_d    = m.AWLEN;
          state_d  = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (decerr_q |
            (m.AWVALID & aw_rdy[sel_q]))
          state_d = ST_DATA;
      end
      ST_DATA: begin
        if (w_hs) begin
          cnt_d = cnt_q + 8'd1;
          if (m.WLAST) begin
            state_d = ST_RESP;
          end else if (cnt_q == len_q) begin
            state_d  = ST_RESP;
            slverr_d = 1'b1;
          end
        end
      end
      ST_RESP: begin
        if (b_hs) state_d = ST_IDLE;
      end
    endcase
  end

  // master-facing ready and response mux
  always_comb begin
    m_awready = 1'b0;
    m_wready  = 1'b0;
    m_bvalid  = 1'b0;
    m_bid     = '0;
    m_bresp   = RESP_OKAY;
    unique case (state_q)
      ST_IDLE: begin
      end
      ST_ADDR: m_awready = decerr_q | aw_rdy[sel_q];
      ST_DATA: m_wready  = decerr_q | w_rdy[sel_q];
      ST_RESP: begin
        if (b_loc) begin
          m_bvalid = 1'b1;
          m_bid    = id_q;
          m_bresp  = slverr_q ? RESP_SLVERR
                              : RESP_DECERR;
        end else begin
          m_bvalid = b_vld[sel_q];
          m_bid    = b_id[sel_q];
          m_bresp  = b_resp[sel_q];
        end
      end
    endcase
  end

  assign m.AWREADY = m_awready;
  assign m.WREADY  = m_wready;
  assign m.BVALID  = m_bvalid;
  assign m.BID     = m_bid;
  assign m.BRESP   = m_bresp;

  // route requests to the selected slave only
  always_comb begin
    for (int n = 0; n < NUM_SLV; n++) begin
      aw_s[n]  = (aw_en && sel_q == 2'(n))
                 ? aw_m : '0;
      w_s[n]   = (w_en && sel_q == 2'(n))
                 ? w_m : '0;
      b_rdy[n] = b_en && sel_q == 2'(n) &&
                 m.BREADY;
    end
  end

  assign {s0.AWID, s0.AWADDR, s0.AWLEN,
          s0.AWSIZE, s0.AWBURST, s0.AWLOCK,
          s0.AWCACHE, s0.AWPROT, s0.AWQOS,
          s0.AWREGION, s0.AWUSER,
          s0.AWVALID} = aw_s[0];
  assign {s1.AWID, s1.AWADDR, s1.AWLEN,
          s1.AWSIZE, s1.AWBURST, s1.AWLOCK,
          s1.AWCACHE, s1.AWPROT, s1.AWQOS,
          s1.AWREGION, s1.AWUSER,
          s1.AWVALID} = aw_s[1];
  assign {s2.AWID, s2.AWADDR, s2.AWLEN,
          s2.AWSIZE, s2.AWBURST, s2.AWLOCK,
          s2.AWCACHE, s2.AWPROT, s2.AWQOS,
          s2.AWREGION, s2.AWUSER,
          s2.AWVALID} = aw_s[2];
  assign {s3.AWID, s3.AWADDR, s3.AWLEN,
          s3.AWSIZE, s3.AWBURST, s3.AWLOCK,
          s3.AWCACHE, s3.AWPROT, s3.AWQOS,
          s3.AWREGION, s3.AWUSER,
          s3.AWVALID} = aw_s[3];

  assign {s0.WDATA, s0.WSTRB, s0.WLAST,
          s0.WUSER, s0.WVALID} = w_s[0];
  assign {s1.WDATA, s1.WSTRB, s1.WLAST,
          s1.WUSER, s1.WVALID} = w_s[1];
  assign {s2.WDATA, s2.WSTRB, s2.WLAST,
          s2.WUSER, s2.WVALID} = w_s[2];
  assign {s3.WDATA, s3.WSTRB, s3.WLAST,
          s3.WUSER, s3.WVALID} = w_s[3];

  assign s0.BREADY = b_rdy[0];
  assign s1.BREADY = b_rdy[1];
  assign s2.BREADY = b_rdy[2];
  assign s3.BREADY = b_rdy[3];

  // state and burst registers
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      decerr_q <= 1'b0;
      slverr_q <= 1'b0;
      id_q     <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      decerr_q <= decerr_d;
      slverr_q <= slverr_d;
      id_q     <= id_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_axi_slave_demux_w.sv
// Directed bench for axi_slave_demux_w.
// Slave 3 is absent (SLV_EN = 4'b0111).
module tb_axi_slave_demux_w;

  localparam int DW = 32;
  localparam int AW = 32;

  logic ACLK    = 1'b0;
  logic ARESETn = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  always #5 ACLK = ~ACLK;

  axi_slave_demux_w_if #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .ID_WIDTH(8), .USER_WIDTH(8)
  ) m_if ();
  axi_slave_demux_w_if #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .ID_WIDTH(8), .USER_WIDTH(8)
  ) s_if0 ();
  axi_slave_demux_w_if #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .ID_WIDTH(8), .USER_WIDTH(8)
  ) s_if1 ();
  axi_slave_demux_w_if #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .ID_WIDTH(8), .USER_WIDTH(8)
  ) s_if2 ();
  axi_slave_demux_w_if #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .ID_WIDTH(8), .USER_WIDTH(8)
  ) s_if3 ();

  axi_slave_demux_w #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .ID_WIDTH   (8),
    .USER_WIDTH (8),
    .SLV_EN     (4'b0111)
  ) dut (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .m       (m_if),
    .s0      (s_if0),
    .s1      (s_if1),
    .s2      (s_if2),
    .s3      (s_if3)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h",
             tag, obs, want);
    end
  endtask

  task automatic cyc();
    @(posedge ACLK);
    #1;
  endtask

  task automatic set_aw(input logic [31:0] a,
                        input logic [7:0]  len,
                        input logic [7:0]  id);
    m_if.AWADDR  = a;
    m_if.AWLEN   = len;
    m_if.AWID    = id;
    m_if.AWVALID = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    m_if.AWID = '0; m_if.AWADDR = '0;
    m_if.AWLEN = '0; m_if.AWSIZE = 3'd2;
    m_if.AWBURST = 2'b01; m_if.AWLOCK = 1'b0;
    m_if.AWCACHE = '0; m_if.AWPROT = '0;
    m_if.AWQOS = '0; m_if.AWREGION = '0;
    m_if.AWUSER = '0; m_if.AWVALID = 1'b0;
    m_if.WDATA = '0; m_if.WSTRB = '1;
    m_if.WLAST = 1'b0; m_if.WUSER = '0;
    m_if.WVALID = 1'b0; m_if.BREADY = 1'b0;
    s_if0.AWREADY = 0; s_if0.WREADY = 0;
    s_if0.BID = 0; s_if0.BRESP = 0;
    s_if0.BVALID = 0;
    s_if1.AWREADY = 0; s_if1.WREADY = 0;
    s_if1.BID = 0; s_if1.BRESP = 0;
    s_if1.BVALID = 0;
    s_if2.AWREADY = 0; s_if2.WREADY = 0;
    s_if2.BID = 0; s_if2.BRESP = 0;
    s_if2.BVALID = 0;
    s_if3.AWREADY = 0; s_if3.WREADY = 0;
    s_if3.BID = 0; s_if3.BRESP = 0;
    s_if3.BVALID = 0;

    // reset state
    #1;
    chk("rst_awready", m_if.AWREADY, 0);
    chk("rst_wready", m_if.WREADY, 0);
    chk("rst_bvalid", m_if.BVALID, 0);
    chk("rst_s_awvalid",
        {s_if0.AWVALID, s_if1.AWVALID,
         s_if2.AWVALID, s_if3.AWVALID}, 0);
    cyc(); cyc();
    ARESETn = 1'b1;
    cyc();

    // mapped burst to s1, 4 beats
    s_if1.AWREADY = 1; s_if1.WREADY = 1;
    set_aw(32'h4000_0010, 8'd3, 8'h5A);
    #1;
    chk("a_idle_awready", m_if.AWREADY, 0);
    chk("a_idle_s1_awv", s_if1.AWVALID, 0);
    cyc();
    chk("a_s1_awvalid", s_if1.AWVALID, 1);
    chk("a_s1_awaddr", s_if1.AWADDR,
        32'h4000_0010);
    chk("a_s1_awid", s_if1.AWID, 8'h5A);
    chk("a_s1_awlen", s_if1.AWLEN, 3);
    chk("a_s1_awburst", s_if1.AWBURST, 1);
    chk("a_m_awready", m_if.AWREADY, 1);
    chk("a_other_awv",
        {s_if0.AWVALID, s_if2.AWVALID,
         s_if3.AWVALID}, 0);
    chk("a_s0_awaddr", s_if0.AWADDR, 0);
    cyc();
    m_if.AWVALID = 0;
    m_if.WVALID  = 1;
    for (int i = 0; i < 4; i++) begin
      m_if.WDATA = 32'hA000_0000 + i;
      m_if.WLAST = (i == 3);
      #1;
      chk("a_wready", m_if.WREADY, 1);
      chk("a_s1_wdata", s_if1.WDATA,
          32'hA000_0000 + i);
      chk("a_other_wv",
          {s_if0.WVALID, s_if2.WVALID,
           s_if3.WVALID}, 0);
      cyc();
    end
    m_if.WVALID = 0; m_if.WLAST = 0;
    s_if1.BVALID = 1; s_if1.BID = 8'h5A;
    s_if1.BRESP = 2'b00;
    m_if.BREADY = 1;
    #1;
    chk("a_bvalid", m_if.BVALID, 1);
    chk("a_bid", m_if.BID, 8'h5A);
    chk("a_bresp", m_if.BRESP, 0);
    chk("a_s1_bready", s_if1.BREADY, 1);
    chk("a_s0_bready", s_if0.BREADY, 0);
    chk("a_resp_wready", m_if.WREADY, 0);
    cyc();
    s_if1.BVALID = 0;
    #1;
    chk("a_done_bvalid", m_if.BVALID, 0);

    // unmapped s3 burst, DECERR
    m_if.BREADY = 0;
    s_if3.AWREADY = 1; s_if3.WREADY = 1;
    set_aw(32'hC000_0000, 8'd1, 8'h33);
    cyc();
    chk("b_awready", m_if.AWREADY, 1);
    chk("b_s3_awvalid", s_if3.AWVALID, 0);
    cyc();
    m_if.AWVALID = 0;
    m_if.WVALID = 1; m_if.WLAST = 0;
    #1;
    chk("b_wready0", m_if.WREADY, 1);
    chk("b_s3_wvalid", s_if3.WVALID, 0);
    cyc();
    m_if.WLAST = 1;
    #1;
    chk("b_wready1", m_if.WREADY, 1);
    cyc();
    m_if.WVALID = 0; m_if.WLAST = 0;
    #1;
    chk("b_bvalid", m_if.BVALID, 1);
    chk("b_bresp", m_if.BRESP, 2'b11);
    chk("b_bid", m_if.BID, 8'h33);
    m_if.BREADY = 1;
    #1;
    chk("b_s3_bready", s_if3.BREADY, 0);
    cyc();
    chk("b_done_bvalid", m_if.BVALID, 0);
    s_if3.AWREADY = 0; s_if3.WREADY = 0;

    // W presented before AW
    s_if0.AWREADY = 1; s_if0.WREADY = 1;
    m_if.WVALID = 1; m_if.WLAST = 1;
    m_if.WDATA = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("c_early_wready", m_if.WREADY, 0);
      chk("c_early_s0_wv", s_if0.WVALID, 0);
      cyc();
    end
    set_aw(32'h0000_0100, 8'd0, 8'h11);
    #1;
    chk("c_idle_wready", m_if.WREADY, 0);
    cyc();
    chk("c_addr_wready", m_if.WREADY, 0);
    chk("c_addr_awready", m_if.AWREADY, 1);
    cyc();
    m_if.AWVALID = 0;
    #1;
    chk("c_wready", m_if.WREADY, 1);
    chk("c_s0_wdata", s_if0.WDATA,
        32'hDEAD_BEEF);
    chk("c_s0_wlast", s_if0.WLAST, 1);
    cyc();
    m_if.WVALID = 0; m_if.WLAST = 0;
    s_if0.BVALID = 1; s_if0.BID = 8'h11;
    s_if0.BRESP = 2'b00;
    #1;
    chk("c_bvalid", m_if.BVALID, 1);
    chk("c_bid", m_if.BID, 8'h11);
    chk("c_bresp", m_if.BRESP, 0);
    cyc();
    s_if0.BVALID = 0;
    #1;
    chk("c_done_bvalid", m_if.BVALID, 0);

    // missing WLAST -> SLVERR after AWLEN+1
    set_aw(32'h4000_0000, 8'd2, 8'h77);
    cyc(); cyc();
    m_if.AWVALID = 0;
    m_if.WVALID = 1; m_if.WLAST = 0;
    for (int i = 0; i < 3; i++) begin
      m_if.WDATA = 32'(i);
      #1;
      chk("d_wready", m_if.WREADY, 1);
      chk("d_early_bvalid", m_if.BVALID, 0);
      cyc();
    end
    m_if.WVALID = 0;
    #1;
    chk("d_bvalid", m_if.BVALID, 1);
    chk("d_bresp", m_if.BRESP, 2'b10);
    chk("d_bid", m_if.BID, 8'h77);
    chk("d_s1_bready", s_if1.BREADY, 0);
    cyc();
    chk("d_done_bvalid", m_if.BVALID, 0);

    // s2 holds BVALID, master stalls B
    s_if2.AWREADY = 1; s_if2.WREADY = 1;
    set_aw(32'h8000_0000, 8'd0, 8'h22);
    cyc(); cyc();
    m_if.AWVALID = 0;
    m_if.WVALID = 1; m_if.WLAST = 1;
    #1;
    chk("e_wready", m_if.WREADY, 1);
    cyc();
    m_if.WVALID = 0; m_if.WLAST = 0;
    m_if.BREADY = 0;
    s_if2.BVALID = 1; s_if2.BID = 8'h22;
    s_if2.BRESP = 2'b00;
    set_aw(32'h0000_0000, 8'd0, 8'h99);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("e_hold_bv_awr",
          {m_if.BVALID, m_if.AWREADY}, 2'b10);
      chk("e_s2_bready_lo", s_if2.BREADY, 0);
      cyc();
    end
    m_if.BREADY = 1;
    #1;
    chk("e_s2_bready_hi", s_if2.BREADY, 1);
    chk("e_bid", m_if.BID, 8'h22);
    cyc();
    s_if2.BVALID = 0;
    #1;
    chk("e_exit_awready", m_if.AWREADY, 0);
    m_if.AWVALID = 0;
    cyc();
    chk("e_stay_idle", m_if.AWREADY, 0);

    // reset mid-burst, then clean OKAY burst
    set_aw(32'h0000_0200, 8'd3, 8'h44);
    cyc(); cyc();
    m_if.AWVALID = 0;
    m_if.WVALID = 1; m_if.WLAST = 0;
    m_if.WDATA = 32'd1;
    cyc();
    m_if.WDATA = 32'd2;
    #1;
    chk("f_beat2_wready", m_if.WREADY, 1);
    ARESETn = 1'b0;
    #1;
    chk("f_rst_wready", m_if.WREADY, 0);
    chk("f_rst_s0_wv", s_if0.WVALID, 0);
    chk("f_rst_awready", m_if.AWREADY, 0);
    chk("f_rst_bvalid", m_if.BVALID, 0);
    cyc();
    ARESETn = 1'b1;
    m_if.WVALID = 0;
    cyc();
    set_aw(32'h0000_0300, 8'd1, 8'h45);
    #1;
    chk("f_idle_awready", m_if.AWREADY, 0);
    cyc();
    chk("f_addr_awready", m_if.AWREADY, 1);
    cyc();
    m_if.AWVALID = 0;
    m_if.WVALID = 1; m_if.WLAST = 0;
    #1;
    chk("f_wready0", m_if.WREADY, 1);
    cyc();
    m_if.WLAST = 1;
    #1;
    chk("f_mid_bvalid", m_if.BVALID, 0);
    chk("f_wready1", m_if.WREADY, 1);
    cyc();
    m_if.WVALID = 0; m_if.WLAST = 0;
    s_if0.BVALID = 1; s_if0.BID = 8'h45;
    s_if0.BRESP = 2'b00;
    #1;
    chk("f_bvalid", m_if.BVALID, 1);
    chk("f_bresp", m_if.BRESP, 0);
    chk("f_bid", m_if.BID, 8'h45);
    cyc();
    s_if0.BVALID = 0;
    #1;
    chk("f_done_bvalid", m_if.BVALID, 0);

    $display("CHECKS %0d ERRORS %0d",
             checks, errors);
    $finish;
  end

endmodule
